vga_ctrl: RTL



---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_delay.sv | 25 ++
 rtl/vga_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults and pixel/sync pipeline types
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PIX_LAT  = 2;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  // hs/vs are active-high "inside sync region"; pins invert them
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_flags_t;
  localparam sync_flags_t FLAGS_IDLE = '0;
endpackage

// File: rtl/vga_delay.sv
// vga_delay: DEPTH-stage shift register with async reset to RST_VAL; DEPTH=0 is a wire
module vga_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  if (DEPTH == 0) begin : g_wire
    assign o_q = i_d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr_q [DEPTH];
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= RST_VAL;
      end else begin
        sr_q[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    assign o_q = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing counters, pixel request issue, and latency-aligned sync/blank/RGB output
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIX_LAT  = DEF_PIX_LAT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic       o_req,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_frame_start,
  output logic       o_line_start,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic [7:0] o_VGA_R,
  output logic [7:0] o_VGA_G,
  output logic [7:0] o_VGA_B,
  output logic       o_H_sync,
  output logic       o_V_sync,
  output logic       o_VGA_BLANK_N
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_ctrl: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end
  if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_lat
    $error("vga_ctrl: PIX_LAT must be 0..7");
  end
  logic [9:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic h_end, v_end, req_q, req_d, fs_q, fs_d, ls_q, ls_d;
  logic hs_n_q, hs_n_d, vs_n_q, vs_n_d, blank_n_q, blank_n_d;
  sync_flags_t flags_q, flags_d, flags_dly;
  rgb_t rgb_q, rgb_d;
  always_comb begin
    h_end     = h_q == 10'(H_TOTAL - 1);
    v_end     = v_q == 10'(V_TOTAL - 1);
    h_d       = h_end ? '0 : h_q + 10'd1;
    v_d       = h_end ? (v_end ? '0 : v_q + 10'd1) : v_q;
    req_d     = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    x_d       = req_d ? h_q : '0;
    y_d       = req_d ? v_q : '0;
    fs_d      = req_d && h_q == '0 && v_q == '0;
    ls_d      = req_d && h_q == '0;
    flags_d.hs     = h_q >= 10'(H_ACTIVE + H_FP) && h_q < 10'(H_ACTIVE + H_FP + H_SYNC);
    flags_d.vs     = v_q >= 10'(V_ACTIVE + V_FP) && v_q < 10'(V_ACTIVE + V_FP + V_SYNC);
    flags_d.active = req_d;
    rgb_d     = flags_dly.active ? '{r: i_r, g: i_g, b: i_b} : '0;
    hs_n_d    = ~flags_dly.hs;
    vs_n_d    = ~flags_dly.vs;
    blank_n_d = flags_dly.active;
  end
  // aligns the request-side flags with data returning PIX_LAT cycles later
  vga_delay #(
    .WIDTH  ($bits(sync_flags_t)),
    .DEPTH  (PIX_LAT),
    .RST_VAL(FLAGS_IDLE)
  ) u_flag_dly (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (flags_q),
    .o_q    (flags_dly)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      req_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
      ls_q      <= 1'b0;
      flags_q   <= FLAGS_IDLE;
      rgb_q     <= '0;
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      req_q     <= req_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      ls_q      <= ls_d;
      flags_q   <= flags_d;
      rgb_q     <= rgb_d;
      hs_n_q    <= hs_n_d;
      vs_n_q    <= vs_n_d;
      blank_n_q <= blank_n_d;
    end
  assign o_req         = req_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_frame_start = fs_q;
  assign o_line_start  = ls_q;
  assign o_VGA_R       = rgb_q.r;
  assign o_VGA_G       = rgb_q.g;
  assign o_VGA_B       = rgb_q.b;
  assign o_H_sync      = hs_n_q;
  assign o_V_sync      = vs_n_q;
  assign o_VGA_BLANK_N = blank_n_q;
endmodule
